hilo_mdu_seq: RTL and testbench

// - Multi-cycle multiply/divide sequencer for MULT/MULTU/DIV/DIVU, sitting beside the E-stage ALU.
// - Accepts one op from E stage, holds the pipeline via stall_o while iterating, then pulses done_o.
// - In the done_o cycle it presents hi_o/lo_o with hregwrite_o=2'b11 so the HI/LO write travels down M/W.

---
 rtl/hilo_mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_hilo_mdu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO beside the E-stage ALU.
// Define MDU_FAST_MUL_EN for single-cycle multiply; divide always iterates.
module hilo_mdu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         flush_i,
  output logic         stall_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic [1:0]   hregwrite_o
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic [W-1:0]   aRaw;
  logic           divOp;
  logic           negQ;
  logic           negR;
  logic           divZero;

  logic           inSigned;
  logic           aNeg;
  logic           bNeg;
  logic [W-1:0]   aAbs;
  logic [W-1:0]   bAbs;

  logic [W:0]     mulSum;
  logic [W:0]     divShift;
  logic [W:0]     divDiff;
  logic [2*W-1:0] nxtAcc;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [2*W-1:0] result;

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] aExt;
  logic [2*W-1:0] bExt;
  logic [2*W-1:0] fastProd;

  // Sign-extended 2W product truncated to 2W is exact for both MULT and MULTU.
  always_comb begin
    aExt = op_i[0] ? {{W{1'b0}}, a_i} : {{W{a_i[W-1]}}, a_i};
    bExt = op_i[0] ? {{W{1'b0}}, b_i} : {{W{b_i[W-1]}}, b_i};
    fastProd = aExt * bExt;
  end
`endif

  always_comb begin
    inSigned = ~op_i[0];
    aNeg = inSigned & a_i[W-1];
    bNeg = inSigned & b_i[W-1];
    aAbs = aNeg ? -a_i : a_i;
    bAbs = bNeg ? -b_i : b_i;
  end

  // acc: multiply {partial, multiplier}; divide {remainder, quotient}.
  always_comb begin
    mulSum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : '0)};
    divShift = {acc[2*W-1:W], acc[W-1]};
    divDiff = divShift - {1'b0, opnd};
    nxtAcc = '0;
    if (!divOp) begin
      nxtAcc = {mulSum, acc[W-1:1]};
    end else if (!divDiff[W]) begin
      nxtAcc = {divDiff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      nxtAcc = {divShift[W-1:0], acc[W-2:0], 1'b0};
    end
    quo = nxtAcc[W-1:0];
    rem = nxtAcc[2*W-1:W];
    result = '0;
    if (!divOp) begin
      result = negQ ? -nxtAcc : nxtAcc;
    end else if (divZero) begin
      result = {aRaw, {W{1'b1}}};
    end else begin
      result = {(negR ? -rem : rem), (negQ ? -quo : quo)};
    end
  end

  assign stall_o = (state == IDLE && start_i && !flush_i) ||
                   (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      aRaw        <= '0;
      divOp       <= 1'b0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      divZero     <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      done_o      <= 1'b0;
      hregwrite_o <= 2'b00;
    end else begin
      done_o      <= 1'b0;
      hregwrite_o <= 2'b00;
      unique case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
`ifdef MDU_FAST_MUL_EN
            if (!op_i[1]) begin
              {hi_o, lo_o} <= fastProd;
              done_o       <= 1'b1;
              hregwrite_o  <= 2'b11;
              state        <= DONE;
            end else
`endif
            begin
              divOp   <= op_i[1];
              negQ    <= aNeg ^ bNeg;
              negR    <= aNeg;
              divZero <= (b_i == '0);
              aRaw    <= a_i;
              opnd    <= op_i[1] ? bAbs : aAbs;
              acc     <= {{W{1'b0}}, (op_i[1] ? aAbs : bAbs)};
              cnt     <= CW'(W - 1);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc <= nxtAcc;
            if (cnt == '0) begin
              {hi_o, lo_o} <= result;
              done_o       <= 1'b1;
              hregwrite_o  <= 2'b11;
              state        <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu_seq.sv
// Directed-vector bench for hilo_mdu_seq: results, latency, stall, flush, reset.
// Build with MDU_FAST_MUL_EN to expect single-cycle multiply latency.
module tb_hilo_mdu_seq;

  localparam int W = 32;
  localparam int DIV_LAT = W + 1;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         stall_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic [1:0]   hregwrite_o;

  int checks = 0;
  int failures = 0;

  hilo_mdu_seq #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .op_i(op_i),
    .a_i(a_i),
    .b_i(b_i),
    .flush_i(flush_i),
    .stall_o(stall_o),
    .done_o(done_o),
    .hi_o(hi_o),
    .lo_o(lo_o),
    .hregwrite_o(hregwrite_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        nm;
  } vec_t;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic doOp(input vec_t v, input int lat);
    int cyc;
    int stallCnt;
    bit got;
    @(negedge clk);
    start_i = 1'b1;
    op_i = v.op;
    a_i = v.a;
    b_i = v.b;
    #1;
    stallCnt = stall_o ? 1 : 0;
    got = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (stall_o) stallCnt++;
      if (done_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({v.nm, " done_seen"}, 64'(got), 64'd1);
    check({v.nm, " latency"}, 64'(cyc), 64'(lat));
    check({v.nm, " stall_cycles"}, 64'(stallCnt), 64'(lat));
    check({v.nm, " hi"}, 64'(hi_o), 64'(v.hi));
    check({v.nm, " lo"}, 64'(lo_o), 64'(v.lo));
    check({v.nm, " hregwrite"}, 64'(hregwrite_o), 64'd3);
    @(posedge clk);
    #1;
    check({v.nm, " done_pulse"}, 64'({done_o, hregwrite_o}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] prevHi;
    logic [W-1:0] prevLo;
    bit seenDone;

    vecs[0]  = '{DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         "divu_100_7"};
    vecs[1]  = '{DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   "div_m7_2"};
    vecs[2]  = '{MULT,  32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   "mult_m3_5"};
    vecs[3]  = '{DIVU,  32'h00001234,   32'd0,          32'h00001234,   32'hFFFFFFFF,   "divu_by0"};
    vecs[4]  = '{DIV,   32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   "div_ovf"};
    vecs[5]  = '{DIV,   32'h80000000,   32'd0,          32'h80000000,   32'hFFFFFFFF,   "div_by0_neg"};
    vecs[6]  = '{MULTU, 32'd6,          32'd7,          32'd0,          32'd42,         "multu_6_7"};
    vecs[7]  = '{DIV,   32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   "div_7_m2"};
    vecs[8]  = '{MULT,  32'h80000000,   32'h80000000,   32'h40000000,   32'd0,          "mult_min_min"};
    vecs[9]  = '{MULT,  32'd7,          32'hFFFFFFFD,   32'hFFFFFFFF,   32'hFFFFFFEB,   "mult_7_m3"};
    vecs[10] = '{DIVU,  32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   "divu_max_1"};
    vecs[11] = '{DIV,   32'd0,          32'd5,          32'd0,          32'd0,          "div_0_5"};
    vecs[12] = '{MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   "multu_max"};

    rst = 1'b1;
    start_i = 1'b0;
    op_i = 2'b00;
    a_i = '0;
    b_i = '0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {28'd0, done_o, stall_o, hregwrite_o, hi_o | lo_o},
          64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      doOp(vecs[i], vecs[i].op[1] ? DIV_LAT : MUL_LAT);
    end
    prevHi = vecs[12].hi;
    prevLo = vecs[12].lo;

    // Flush in RUN at T10
    @(negedge clk);
    start_i = 1'b1;
    op_i = DIVU;
    a_i = 32'd1000;
    b_i = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    check("flush T10 stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush T11 stall", 64'(stall_o), 64'd0);
    seenDone = done_o;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o) seenDone = 1'b1;
    end
    check("flush no done", 64'(seenDone), 64'd0);
    check("flush hi/lo kept", {hi_o, lo_o}, {prevHi, prevLo});

    // start and flush together in IDLE
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = DIV;
    a_i = 32'd50;
    b_i = 32'd5;
    #1;
    check("idle start+flush stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    check("idle start+flush next", 64'({stall_o, done_o}), 64'd0);
    start_i = 1'b0;
    flush_i = 1'b0;
    seenDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o || stall_o) seenDone = 1'b1;
    end
    check("idle start+flush no op", 64'(seenDone), 64'd0);
    check("idle start+flush hi/lo", {hi_o, lo_o}, {prevHi, prevLo});

    // Reset mid-op at T5
    @(negedge clk);
    start_i = 1'b1;
    op_i = DIVU;
    a_i = 32'd999;
    b_i = 32'd10;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset stall", 64'(stall_o), 64'd1);
    rst = 1'b1;
    #1;
    check("reset hi/lo", {hi_o, lo_o}, 64'd0);
    check("reset ctl", 64'({done_o, stall_o, hregwrite_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doOp(vecs[0], DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
